// File: rtl/rom_bist_ctrl.sv
// rom_bist_ctrl -- ROM built-in self-test sweep controller.
//
// Purpose:
//   Reads a contiguous (optionally wrapping) address range out of a
//   synchronous ROM macro and compresses every returned word into a 32-bit
//   MISR signature (CRC-32 polynomial 32'h04C11DB7, seed 32'hFFFFFFFF).
//   At the end of the sweep the signature is compared with an expected
//   value and the result is reported on pass, alongside a one-cycle done.
//
// Ports:
//   clk        rising-edge clock for all logic
//   rst        synchronous, active-high reset
//   start      one-cycle sweep request, honoured only in IDLE
//   addr_lo    first address of the sweep (sampled with start)
//   addr_hi    last address of the sweep, inclusive (sampled with start)
//   exp_sig    expected signature (sampled with start)
//   busy       high while the sweep is issuing or draining reads
//   done       one-cycle pulse when the sweep completes
//   pass       signature matched exp_sig; valid from done to the next start
//   sig        running / final MISR signature
//   rom_cs     ROM chip select
//   rom_addr   ROM address
//   rom_dout   ROM read data, valid READ_LAT edges after cs/addr are sampled
//
// Optional feature (macro ROM_BIST_DUMP_EN):
//   dump_valid / dump_addr / dump_data present every captured word together
//   with its address, one cycle per word, in issue order. Without the macro
//   these ports and their logic are absent.

module rom_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  input  logic [31:0]           exp_sig,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           sig,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
`ifdef ROM_BIST_DUMP_EN
  ,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] hi_q;
  logic [31:0]           exp_q;
  logic [1:0]            drain_cnt;
  logic [READ_LAT-1:0]   vld;
  logic                  capture;
  logic [31:0]           sig_nxt;

  // One MISR step: shift with CRC-32 feedback, then fold in the data word.
  function automatic logic [31:0] misr_step(input logic [31:0] s,
                                            input logic [DATA_WIDTH-1:0] d);
    logic [31:0] fb;
    fb = s[31] ? 32'h04C11DB7 : 32'h0000_0000;
    return ({s[30:0], 1'b0} ^ fb) ^ 32'(d);
  endfunction

  // The oldest stage of the valid pipe marks the cycle in which rom_dout
  // belongs to a read we issued; that is the only time data is folded in.
  assign capture = vld[READ_LAT-1];
  assign sig_nxt = capture ? misr_step(sig, rom_dout) : sig;

  // Main sweep FSM. Outputs are registered. The valid pipe keeps shifting
  // in DRAIN so reads still in flight after the last issue are captured.
  // pass is evaluated against sig_nxt so it already includes the final word
  // captured on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      sig       <= 32'hFFFF_FFFF;
      vld       <= '0;
      drain_cnt <= 2'd0;
      hi_q      <= '0;
      exp_q     <= 32'h0000_0000;
    end else begin
      vld[0] <= rom_cs;
      for (int i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
      sig <= sig_nxt;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            rom_cs   <= 1'b1;
            rom_addr <= addr_lo;
            hi_q     <= addr_hi;
            exp_q    <= exp_sig;
            sig      <= 32'hFFFF_FFFF;
            pass     <= 1'b0;
          end
        end
        ISSUE: begin
          // Natural overflow of rom_addr gives the wrap through address 0.
          if (rom_addr == hi_q) begin
            state     <= DRAIN;
            rom_cs    <= 1'b0;
            drain_cnt <= 2'd0;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(READ_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_nxt == exp_q);
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_BIST_DUMP_EN
  logic [ADDR_WIDTH-1:0] apipe [READ_LAT];

  // Address pipe mirrors the valid pipe so each captured word can be
  // reported with the address it was read from.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        apipe[i] <= '0;
      end
    end else begin
      apipe[0] <= rom_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        apipe[i] <= apipe[i-1];
      end
      dump_valid <= capture;
      if (capture) begin
        dump_addr <= apipe[READ_LAT-1];
        dump_data <= rom_dout;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_bist_ctrl.sv
// tb_rom_bist_ctrl -- self-checking bench for rom_bist_ctrl.
// Two instances share the stimulus: dut1 (READ_LAT=1) and dut3 (READ_LAT=3),
// each with its own behavioural ROM of matching latency over one memory.
// Expected addresses are queued when a sweep is launched and popped against
// the addresses observed on rom_cs cycles.

module tb_rom_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  addr_lo, addr_hi;
  logic [31:0] exp_sig;

  logic        busy1, done1, pass1, cs1;
  logic [31:0] sig1;
  logic [9:0]  addr1;
  logic [7:0]  dout1;
  logic        busy3, done3, pass3, cs3;
  logic [31:0] sig3;
  logic [9:0]  addr3;
  logic [7:0]  dout3;
`ifdef ROM_BIST_DUMP_EN
  logic        dv1, dv3;
  logic [9:0]  da1, da3;
  logic [7:0]  dd1, dd3;
`endif

  logic [7:0] mem [1024];
  logic [7:0] p1;
  logic [7:0] p3 [3];

  int checks = 0;
  int errors = 0;

  int          exp_addr_q[$];
  int          obs_addr_q[$];
  int          exp_data_q[$];
  int          obs_dump_addr_q[$];
  int          obs_dump_data_q[$];
  int          obs_done_c, obs_done_n, obs_cs_n, obs_busy_n;
  logic [31:0] obs_sig, hold_sig, post_rst_sig;
  logic        obs_pass, hold_pass, post_rst_busy, post_rst_cs;

  always #5 clk = ~clk;

  rom_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .exp_sig(exp_sig), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1),
    .rom_cs(cs1), .rom_addr(addr1), .rom_dout(dout1)
`ifdef ROM_BIST_DUMP_EN
    , .dump_valid(dv1), .dump_addr(da1), .dump_data(dd1)
`endif
  );

  rom_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .exp_sig(exp_sig), .busy(busy3), .done(done3), .pass(pass3), .sig(sig3),
    .rom_cs(cs3), .rom_addr(addr3), .rom_dout(dout3)
`ifdef ROM_BIST_DUMP_EN
    , .dump_valid(dv3), .dump_addr(da3), .dump_data(dd3)
`endif
  );

  // Behavioural synchronous ROMs with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    p1    <= cs1 ? mem[addr1] : 8'h00;
    p3[0] <= cs3 ? mem[addr3] : 8'h00;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout1 = p1;
  assign dout3 = p3[2];

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [7:0] d);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ 32'h04C11DB7;
    return r ^ {24'h0, d};
  endfunction

  function automatic logic [31:0] model_sig(input int lo, input int n);
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) s = misr(s, mem[(lo + i) % 1024]);
    return s;
  endfunction

  task automatic push_expected(input int lo, input int n);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back((lo + i) % 1024);
      exp_data_q.push_back(int'(mem[(lo + i) % 1024]));
    end
  endtask

  task automatic applyStimulus(input logic [9:0] lo, input logic [9:0] hi,
                               input logic [31:0] ex);
    @(negedge clk);
    addr_lo = lo;
    addr_hi = hi;
    exp_sig = ex;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Launches a sweep and records what the selected instance does, one sample
  // per cycle, #1 after each rising edge. Cycle c=1 is the cycle after the
  // edge that sampled start. poke_c / rst_c pulse start / rst in cycle c.
  task automatic run_sweep(input int sel, input logic [9:0] lo, input logic [9:0] hi,
                           input logic [31:0] ex, input int poke_c, input int rst_c,
                           input int budget);
    logic        cs, bsy, dn, ps;
    logic [9:0]  adr;
    logic [31:0] sg;
    obs_addr_q.delete();
    obs_dump_addr_q.delete();
    obs_dump_data_q.delete();
    obs_done_c = -1;
    obs_done_n = 0;
    obs_cs_n   = 0;
    obs_busy_n = 0;
    applyStimulus(lo, hi, ex);
    for (int c = 1; c <= budget; c++) begin
      if (sel == 0) begin
        cs = cs1; adr = addr1; bsy = busy1; dn = done1; sg = sig1; ps = pass1;
      end else begin
        cs = cs3; adr = addr3; bsy = busy3; dn = done3; sg = sig3; ps = pass3;
      end
      if (cs) begin
        obs_addr_q.push_back(int'(adr));
        obs_cs_n++;
      end
      if (bsy) obs_busy_n++;
      if (dn) begin
        obs_done_n++;
        if (obs_done_c < 0) begin
          obs_done_c = c;
          obs_sig    = sg;
          obs_pass   = ps;
        end
      end
      if (obs_done_c > 0 && c == obs_done_c + 2) begin
        hold_sig  = sg;
        hold_pass = ps;
      end
      if (c == rst_c + 1) begin
        post_rst_busy = bsy;
        post_rst_cs   = cs;
        post_rst_sig  = sg;
      end
`ifdef ROM_BIST_DUMP_EN
      if (sel == 1 && dv3) begin
        obs_dump_addr_q.push_back(int'(da3));
        obs_dump_data_q.push_back(int'(dd3));
      end
`endif
      start = (c == poke_c);
      if (c == poke_c) begin
        addr_lo = lo + 10'd100;
        addr_hi = lo + 10'd100;
        exp_sig = ~ex;
      end
      rst = (c == rst_c);
      if (obs_done_c > 0 && c >= obs_done_c + 3) break;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done1: got %b expected 0", done1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass1: got %b expected 0", pass1); end
    checks++; if (cs1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs1: got %b expected 0", cs1); end
    checks++; if (addr1 !== 10'd0) begin errors++; $display("[TB] FAIL reset_addr1: got %0d expected 0", addr1); end
    checks++; if (sig1 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_sig1: got %h expected ffffffff", sig1); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy3: got %b expected 0", busy3); end
    checks++; if (cs3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs3: got %b expected 0", cs3); end
    checks++; if (sig3 !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_sig3: got %h expected ffffffff", sig3); end
`ifdef ROM_BIST_DUMP_EN
    checks++; if (dv3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dump_valid: got %b expected 0", dv3); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_sweep;
    logic [31:0] es;
    int          a;
    es = model_sig(0, 1024);
    push_expected(0, 1024);
    run_sweep(0, 10'd0, 10'd1023, es, -1, -1, 1100);
    checks++; if (obs_done_c !== 1026) begin errors++; $display("[TB] FAIL full_done_cycle: got %0d expected 1026", obs_done_c); end
    checks++; if (obs_cs_n !== 1024) begin errors++; $display("[TB] FAIL full_cs_cycles: got %0d expected 1024", obs_cs_n); end
    checks++; if (obs_busy_n !== 1025) begin errors++; $display("[TB] FAIL full_busy_cycles: got %0d expected 1025", obs_busy_n); end
    checks++; if (obs_sig !== es) begin errors++; $display("[TB] FAIL full_sig: got %h expected %h", obs_sig, es); end
    checks++; if (obs_pass !== 1'b1) begin errors++; $display("[TB] FAIL full_pass: got %b expected 1", obs_pass); end
    checks++; if (hold_sig !== es) begin errors++; $display("[TB] FAIL full_hold_sig: got %h expected %h", hold_sig, es); end
    checks++; if (hold_pass !== 1'b1) begin errors++; $display("[TB] FAIL full_hold_pass: got %b expected 1", hold_pass); end
    while (exp_addr_q.size() > 0) begin
      a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : -1;
      checks++;
      if (a !== exp_addr_q[0]) begin errors++; $display("[TB] FAIL full_addr: got %0d expected %0d", a, exp_addr_q[0]); end
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic test_single_word;
    logic [31:0] es;
    int          a;
    mem[5] = 8'hA5;
    es = misr(32'hFFFF_FFFF, 8'hA5);
    push_expected(5, 1);
    // start poked in the DONE cycle must be ignored
    run_sweep(0, 10'd5, 10'd5, es, 3, -1, 20);
    checks++; if (obs_done_c !== 3) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d expected 3", obs_done_c); end
    checks++; if (obs_cs_n !== 1) begin errors++; $display("[TB] FAIL single_cs_cycles: got %0d expected 1", obs_cs_n); end
    checks++; if (obs_busy_n !== 2) begin errors++; $display("[TB] FAIL single_busy_cycles: got %0d expected 2", obs_busy_n); end
    checks++; if (obs_sig !== es) begin errors++; $display("[TB] FAIL single_sig: got %h expected %h", obs_sig, es); end
    checks++; if (obs_pass !== 1'b1) begin errors++; $display("[TB] FAIL single_pass: got %b expected 1", obs_pass); end
    a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : -1;
    checks++; if (a !== exp_addr_q.pop_front()) begin errors++; $display("[TB] FAIL single_addr: got %0d expected 5", a); end
  endtask

  task automatic test_wrap;
    logic [31:0] es;
    int          a;
    es = model_sig(1022, 4);
    push_expected(1022, 4);
    run_sweep(0, 10'd1022, 10'd1, es, -1, -1, 30);
    checks++; if (obs_done_c !== 6) begin errors++; $display("[TB] FAIL wrap_done_cycle: got %0d expected 6", obs_done_c); end
    checks++; if (obs_cs_n !== 4) begin errors++; $display("[TB] FAIL wrap_cs_cycles: got %0d expected 4", obs_cs_n); end
    checks++; if (obs_sig !== es) begin errors++; $display("[TB] FAIL wrap_sig: got %h expected %h", obs_sig, es); end
    checks++; if (obs_pass !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pass: got %b expected 1", obs_pass); end
    while (exp_addr_q.size() > 0) begin
      a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : -1;
      checks++;
      if (a !== exp_addr_q[0]) begin errors++; $display("[TB] FAIL wrap_addr: got %0d expected %0d", a, exp_addr_q[0]); end
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic test_corrupt_busy_start;
    logic [31:0] es_good, es_bad;
    int          a;
    es_good = model_sig(10, 31);
    mem[20] = mem[20] ^ 8'h01;
    es_bad  = model_sig(10, 31);
    push_expected(10, 31);
    run_sweep(0, 10'd10, 10'd40, es_good, 5, -1, 60);
    mem[20] = mem[20] ^ 8'h01;
    checks++; if (obs_done_c !== 33) begin errors++; $display("[TB] FAIL corrupt_done_cycle: got %0d expected 33", obs_done_c); end
    checks++; if (obs_done_n !== 1) begin errors++; $display("[TB] FAIL corrupt_done_pulses: got %0d expected 1", obs_done_n); end
    checks++; if (obs_cs_n !== 31) begin errors++; $display("[TB] FAIL corrupt_cs_cycles: got %0d expected 31", obs_cs_n); end
    checks++; if (obs_sig !== es_bad) begin errors++; $display("[TB] FAIL corrupt_sig: got %h expected %h", obs_sig, es_bad); end
    checks++; if (obs_pass !== 1'b0) begin errors++; $display("[TB] FAIL corrupt_pass: got %b expected 0", obs_pass); end
    while (exp_addr_q.size() > 0) begin
      a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : -1;
      checks++;
      if (a !== exp_addr_q[0]) begin errors++; $display("[TB] FAIL corrupt_addr: got %0d expected %0d", a, exp_addr_q[0]); end
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_sweep;
    logic [31:0] es;
    es = model_sig(0, 51);
    run_sweep(0, 10'd0, 10'd50, es, -1, 10, 40);
    checks++; if (post_rst_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", post_rst_busy); end
    checks++; if (post_rst_cs !== 1'b0) begin errors++; $display("[TB] FAIL abort_cs: got %b expected 0", post_rst_cs); end
    checks++; if (post_rst_sig !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL abort_sig: got %h expected ffffffff", post_rst_sig); end
    checks++; if (obs_done_n !== 0) begin errors++; $display("[TB] FAIL abort_done_pulses: got %0d expected 0", obs_done_n); end
    checks++; if (obs_cs_n !== 10) begin errors++; $display("[TB] FAIL abort_cs_cycles: got %0d expected 10", obs_cs_n); end
    es = model_sig(3, 7);
    run_sweep(0, 10'd3, 10'd9, es, -1, -1, 30);
    checks++; if (obs_done_c !== 9) begin errors++; $display("[TB] FAIL after_abort_done_cycle: got %0d expected 9", obs_done_c); end
    checks++; if (obs_sig !== es) begin errors++; $display("[TB] FAIL after_abort_sig: got %h expected %h", obs_sig, es); end
    checks++; if (obs_pass !== 1'b1) begin errors++; $display("[TB] FAIL after_abort_pass: got %b expected 1", obs_pass); end
  endtask

  task automatic test_lat3_dump;
    logic [31:0] es;
    int          a;
    es = model_sig(0, 8);
    push_expected(0, 8);
    run_sweep(1, 10'd0, 10'd7, es, -1, -1, 40);
    checks++; if (obs_done_c !== 12) begin errors++; $display("[TB] FAIL lat3_done_cycle: got %0d expected 12", obs_done_c); end
    checks++; if (obs_cs_n !== 8) begin errors++; $display("[TB] FAIL lat3_cs_cycles: got %0d expected 8", obs_cs_n); end
    checks++; if (obs_busy_n !== 11) begin errors++; $display("[TB] FAIL lat3_busy_cycles: got %0d expected 11", obs_busy_n); end
    checks++; if (obs_sig !== es) begin errors++; $display("[TB] FAIL lat3_sig: got %h expected %h", obs_sig, es); end
    checks++; if (obs_pass !== 1'b1) begin errors++; $display("[TB] FAIL lat3_pass: got %b expected 1", obs_pass); end
`ifdef ROM_BIST_DUMP_EN
    checks++; if (obs_dump_addr_q.size() !== 8) begin errors++; $display("[TB] FAIL lat3_dump_count: got %0d expected 8", obs_dump_addr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      a = (obs_dump_addr_q.size() > 0) ? obs_dump_addr_q.pop_front() : -1;
      checks++; if (a !== exp_addr_q[i]) begin errors++; $display("[TB] FAIL lat3_dump_addr: got %0d expected %0d", a, exp_addr_q[i]); end
      a = (obs_dump_data_q.size() > 0) ? obs_dump_data_q.pop_front() : -1;
      checks++; if (a !== exp_data_q[i]) begin errors++; $display("[TB] FAIL lat3_dump_data: got %0d expected %0d", a, exp_data_q[i]); end
    end
`endif
    while (exp_addr_q.size() > 0) begin
      a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : -1;
      checks++;
      if (a !== exp_addr_q[0]) begin errors++; $display("[TB] FAIL lat3_addr: got %0d expected %0d", a, exp_addr_q[0]); end
      void'(exp_addr_q.pop_front());
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    addr_lo = 10'd0;
    addr_hi = 10'd0;
    exp_sig = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
    test_reset;
    test_full_sweep;
    test_single_word;
    test_wrap;
    test_corrupt_busy_start;
    test_reset_mid_sweep;
    test_lat3_dump;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_bist_ctrl.md
ROM_BIST_CTRL -- requirements
Module: rom_bist_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ROM word width in bits (1..32).
REQ-002 Parameter ADDR_WIDTH, default 10, ROM address width in bits.
REQ-003 Parameter READ_LAT, default 1, cycles from the clk edge sampling rom_cs/rom_addr to valid rom_dout (1..4).
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 Port addr_lo  input  ADDR_WIDTH  first address of sweep, sampled with start.
REQ-008 Port addr_hi  input  ADDR_WIDTH  last address of sweep (inclusive), sampled with start.
REQ-009 Port exp_sig  input  32  expected signature, sampled with start.
REQ-010 Port busy  output  1  high from the cycle after start is accepted until done.
REQ-011 Port done  output  1  one-cycle pulse at sweep end.
REQ-012 Port pass  output  1  sig equals captured exp_sig; valid from done until next accepted start.
REQ-013 Port sig  output  32  running/final MISR signature.
REQ-014 Port rom_cs  output  1  ROM chip select, drives macro cs.
REQ-015 Port rom_addr  output  ADDR_WIDTH  ROM address, drives macro addr.
REQ-016 Port rom_dout  input  DATA_WIDTH  ROM read data.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start; ISSUE->DRAIN after last address issued; DRAIN->DONE after READ_LAT further edges; DONE->IDLE after one cycle.
REQ-018 In ISSUE, rom_cs=1 and rom_addr advances by one per cycle from addr_lo to addr_hi; rom_cs=0 in all other states.
REQ-019 Address increment wraps modulo 2^ADDR_WIDTH; addr_hi < addr_lo sweeps through max address to 0; addr_lo == addr_hi reads exactly one word; word count N = (addr_hi - addr_lo mod 2^ADDR_WIDTH) + 1.
REQ-020 A READ_LAT-deep valid shift register tracks issued reads; rom_dout is folded into sig exactly once per issued address, in issue order.
REQ-021 Signature seeded to 32'hFFFFFFFF on start acceptance; per captured word: sig <= ({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ zero-extended rom_dout.
REQ-022 done is high exactly N+READ_LAT+1 cycles after the cycle in which start was sampled; pass is computed in that same cycle.
REQ-023 start while busy or in DONE is ignored; sweep parameters are not altered.
REQ-024 sig, pass hold their values in IDLE until the next accepted start.

Reset
REQ-025 rst forces IDLE and busy=0, done=0, pass=0, rom_cs=0, rom_addr=0, sig=32'hFFFFFFFF, valid pipeline cleared, on the next edge.
REQ-026 rst asserted mid-sweep aborts with no done pulse; in-flight reads are discarded; rst has priority over start in the same cycle.

Configuration
REQ-027 Macro ROM_BIST_DUMP_EN defined: adds outputs dump_valid (1), dump_addr (ADDR_WIDTH), dump_data (DATA_WIDTH), asserting dump_valid for one cycle per captured word with its address and data, in issue order; reset value 0.
REQ-028 Macro ROM_BIST_DUMP_EN undefined: these ports and their logic do not exist; all other behaviour identical.

Verification
REQ-029 Full sweep lo=0, hi=1023, ROM model from hex file, exp_sig = reference model signature -> done after 1026 cycles (READ_LAT=1), pass=1, rom_cs high exactly 1024 cycles.
REQ-030 Single word lo=hi=5, mem[5]=8'hA5 -> one rom_cs cycle, sig = MISR(32'hFFFFFFFF, 8'hA5), done after 3 cycles.
REQ-031 Wrap lo=1022, hi=1 -> rom_addr sequence 1022,1023,0,1; N=4; done after 6 cycles.
REQ-032 Corrupt one ROM word vs. exp_sig -> done=1, pass=0; start pulsed while busy -> no restart, sweep length unchanged.
REQ-033 rst asserted at 10th ISSUE cycle -> next cycle busy=0, rom_cs=0, sig=32'hFFFFFFFF, no done pulse; subsequent start runs normally.
REQ-034 READ_LAT=3 with ROM_BIST_DUMP_EN, lo=0, hi=7 -> 8 dump_valid pulses, dump_addr 0..7 matching model data, done after 12 cycles.
